// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: one SEG-bit slice per stage, carry registered
// between stages, whole pipe frozen by a single stall derived from the output handshake.
module pipelined_adder #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int STAGES = WIDTH / SEG;

  logic             stall;
  logic [WIDTH-1:0] b_eff;
  logic             c_eff;

  // Subtract as A + ~B + 1; cin has no effect in that mode.
  assign b_eff    = sub ? ~b : b;
  assign c_eff    = sub ? 1'b1 : cin;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : stg
      // REM: operand bits still unconsumed on entry; DONE: result bits known on exit.
      localparam int REM  = WIDTH - gi * SEG;
      localparam int DONE = (gi + 1) * SEG;

      logic [REM-1:0]  a_in;
      logic [REM-1:0]  b_in;
      logic            c_in;
      logic            v_in;
      logic [DONE-1:0] sum_next;
      logic [SEG-1:0]  seg_sum;
      logic            seg_cout;
      logic            valid_reg;
      logic            carry_reg;
      logic [DONE-1:0] sum_reg;

      if (gi == 0) begin : g_src
        assign a_in     = a;
        assign b_in     = b_eff;
        assign c_in     = c_eff;
        assign v_in     = in_valid;
        assign sum_next = seg_sum;
      end else begin : g_src
        assign a_in     = stg[gi-1].g_fwd.a_rem_reg;
        assign b_in     = stg[gi-1].g_fwd.b_rem_reg;
        assign c_in     = stg[gi-1].carry_reg;
        assign v_in     = stg[gi-1].valid_reg;
        assign sum_next = {seg_sum, stg[gi-1].sum_reg};
      end

      assign {seg_cout, seg_sum} = {1'b0, a_in[SEG-1:0]} + {1'b0, b_in[SEG-1:0]}
                                 + {{SEG{1'b0}}, c_in};

      // Bubbles advance like beats; only a stall freezes the slot.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          valid_reg <= 1'b0;
          carry_reg <= 1'b0;
          sum_reg   <= '0;
        end else if (!stall) begin
          valid_reg <= v_in;
          carry_reg <= seg_cout;
          sum_reg   <= sum_next;
        end
      end

      if (gi < STAGES - 1) begin : g_fwd
        logic [REM-SEG-1:0] a_rem_reg;
        logic [REM-SEG-1:0] b_rem_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_rem_reg <= '0;
            b_rem_reg <= '0;
          end else if (!stall) begin
            a_rem_reg <= a_in[REM-1:SEG];
            b_rem_reg <= b_in[REM-1:SEG];
          end
        end
      end else begin : g_last
        logic msb_cin;
        logic ovf_reg;

        // Carry into the MSB falls out of the MSB sum bit and its two operand bits.
        assign msb_cin = seg_sum[SEG-1] ^ a_in[SEG-1] ^ b_in[SEG-1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (!stall) begin
            ovf_reg <= seg_cout ^ msb_cin;
          end
        end
      end
    end
  endgenerate

  assign out_valid = stg[STAGES-1].valid_reg;
  assign sum       = stg[STAGES-1].sum_reg;
  assign cout      = stg[STAGES-1].carry_reg;
  assign ovf       = stg[STAGES-1].g_last.ovf_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: three configurations share one stimulus bus,
// selected by sel; a negedge monitor pushes expected results on accept and pops on emit.
module tb_pipelined_adder;
  localparam int LAT0 = 4;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid_d;
  logic        out_ready_d;
  logic        cin_d;
  logic        sub_d;
  logic [31:0] a_d;
  logic [31:0] b_d;
  int          sel;

  logic        v0, r0, c0, o0;
  logic [15:0] s0;
  logic        v1, r1, c1, o1;
  logic [15:0] s1;
  logic        v2, r2, c2, o2;
  logic [31:0] s2;

  logic        obs_valid, obs_ready, obs_cout, obs_ovf;
  logic [31:0] obs_sum;
  int          cur_w;

  res_t        sb[$];
  res_t        mon_exp;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          n_accept = 0;
  int          n_emit = 0;

  always #5 clk = ~clk;

  pipelined_adder #(.WIDTH(16), .SEG(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d && (sel == 0)), .in_ready(r0),
    .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(v0), .out_ready(out_ready_d), .sum(s0), .cout(c0), .ovf(o0)
  );

  pipelined_adder #(.WIDTH(16), .SEG(16)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d && (sel == 1)), .in_ready(r1),
    .a(a_d[15:0]), .b(b_d[15:0]), .cin(cin_d), .sub(sub_d),
    .out_valid(v1), .out_ready(out_ready_d), .sum(s1), .cout(c1), .ovf(o1)
  );

  pipelined_adder #(.WIDTH(32), .SEG(8)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid_d && (sel == 2)), .in_ready(r2),
    .a(a_d), .b(b_d), .cin(cin_d), .sub(sub_d),
    .out_valid(v2), .out_ready(out_ready_d), .sum(s2), .cout(c2), .ovf(o2)
  );

  always_comb begin
    obs_valid = v0;
    obs_ready = r0;
    obs_sum   = {16'd0, s0};
    obs_cout  = c0;
    obs_ovf   = o0;
    cur_w     = 16;
    if (sel == 1) begin
      obs_valid = v1;
      obs_ready = r1;
      obs_sum   = {16'd0, s1};
      obs_cout  = c1;
      obs_ovf   = o1;
    end else if (sel == 2) begin
      obs_valid = v2;
      obs_ready = r2;
      obs_sum   = s2;
      obs_cout  = c2;
      obs_ovf   = o2;
      cur_w     = 32;
    end
  end

  // Golden model: full-precision add, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                 input logic cv, input logic sv);
    logic [32:0] full;
    logic [31:0] mask;
    logic [31:0] aa;
    logic [31:0] bb;
    res_t        r;
    mask   = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    aa     = av & mask;
    bb     = (sv ? ~bv : bv) & mask;
    full   = {1'b0, aa} + {1'b0, bb} + {32'd0, (sv ? 1'b1 : cv)};
    r.sum  = full[31:0] & mask;
    r.cout = full[w];
    r.ovf  = (aa[w-1] == bb[w-1]) && (r.sum[w-1] != aa[w-1]);
    return r;
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid_d && obs_ready) begin
        sb.push_back(model(cur_w, a_d, b_d, cin_d, sub_d));
        n_accept++;
      end
      if (obs_valid && out_ready_d) begin
        n_emit++;
        n_cmp++;
        if (sb.size() == 0) begin
          n_bad++;
          $display("FAIL sb_unexpected: emitted sum=%h with no beat outstanding, required none", obs_sum);
        end else begin
          mon_exp = sb.pop_front();
          if ({obs_cout, obs_sum, obs_ovf} !== {mon_exp.cout, mon_exp.sum, mon_exp.ovf}) begin
            n_bad++;
            $display("FAIL sb_result(cfg%0d): got cout=%0d sum=%h ovf=%0d, required cout=%0d sum=%h ovf=%0d",
                     sel, obs_cout, obs_sum, obs_ovf, mon_exp.cout, mon_exp.sum, mon_exp.ovf);
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation still running at %0t, required finished", $time);
    $fatal(1, "watchdog expired");
  end

  // Holds in_valid until the beat is accepted; returns at posedge+1 with in_valid still high.
  task automatic drive_beat();
    int waited;
    waited = 0;
    in_valid_d = 1'b1;
    @(negedge clk);
    while (!obs_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!obs_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL accept_timeout: in_ready=%0d after %0d cycles, required 1", obs_ready, waited);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!obs_valid && cyc < 50);
    if (!obs_valid) cyc = -1;
  endtask

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while ((sb.size() != 0 || obs_valid) && cyc < 300);
    n_cmp++;
    if (sb.size() != 0 || obs_valid) begin
      n_bad++;
      $display("FAIL %s_drain: %0d results pending, required 0", tag, sb.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = s;
      #1;
      n_cmp++;
      if ({obs_valid, obs_cout, obs_ovf, obs_sum} !== 35'd0) begin
        n_bad++;
        $display("FAIL reset_outputs(cfg%0d): valid=%0d cout=%0d ovf=%0d sum=%h, required all 0",
                 s, obs_valid, obs_cout, obs_ovf, obs_sum);
      end
      n_cmp++;
      if (obs_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready(cfg%0d): got %0d, required 1", s, obs_ready);
      end
    end
    sel = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_carry_chain();
    int cyc;
    a_d = 32'hFFFF; b_d = 32'h0001; cin_d = 1'b0; sub_d = 1'b0;
    drive_beat();
    in_valid_d = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if (cyc != LAT0) begin
      n_bad++;
      $display("FAIL carry_latency: out_valid after %0d cycles, required %0d", cyc, LAT0);
    end
    n_cmp++;
    if ({obs_cout, obs_sum, obs_ovf} !== {1'b1, 32'h0000, 1'b0}) begin
      n_bad++;
      $display("FAIL carry_result: cout=%0d sum=%h ovf=%0d, required cout=1 sum=0000 ovf=0",
               obs_cout, obs_sum, obs_ovf);
    end
    wait_idle("carry");
  endtask

  task automatic test_overflow();
    int cyc;
    a_d = 32'h7FFF; b_d = 32'h0001; cin_d = 1'b0; sub_d = 1'b0;
    drive_beat();
    in_valid_d = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if ({obs_valid, obs_cout, obs_sum, obs_ovf} !== {1'b1, 1'b0, 32'h8000, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_add: valid=%0d cout=%0d sum=%h ovf=%0d, required valid=1 cout=0 sum=8000 ovf=1",
               obs_valid, obs_cout, obs_sum, obs_ovf);
    end
    wait_idle("ovf_add");
    a_d = 32'h8000; b_d = 32'h0001; cin_d = 1'b0; sub_d = 1'b1;
    drive_beat();
    in_valid_d = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if ({obs_valid, obs_cout, obs_sum, obs_ovf} !== {1'b1, 1'b1, 32'h7FFF, 1'b1}) begin
      n_bad++;
      $display("FAIL ovf_sub: valid=%0d cout=%0d sum=%h ovf=%0d, required valid=1 cout=1 sum=7fff ovf=1",
               obs_valid, obs_cout, obs_sum, obs_ovf);
    end
    wait_idle("ovf_sub");
  endtask

  task automatic test_borrow();
    int cyc;
    a_d = 32'h0005; b_d = 32'h0007; cin_d = 1'b1; sub_d = 1'b1;
    drive_beat();
    in_valid_d = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if ({obs_valid, obs_cout, obs_sum, obs_ovf} !== {1'b1, 1'b0, 32'hFFFE, 1'b0}) begin
      n_bad++;
      $display("FAIL borrow: valid=%0d cout=%0d sum=%h ovf=%0d, required valid=1 cout=0 sum=fffe ovf=0",
               obs_valid, obs_cout, obs_sum, obs_ovf);
    end
    wait_idle("borrow");
  endtask

  task automatic test_back_to_back();
    int emit0;
    int lowcnt;
    emit0  = n_emit;
    lowcnt = 0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          a_d = i; b_d = 32'h1000 * i; cin_d = 1'b0; sub_d = 1'b0;
          drive_beat();
        end
        in_valid_d = 1'b0;
      end
      begin
        int cyc;
        cyc = 0;
        while (!obs_valid && cyc < 50) begin
          @(posedge clk);
          #1;
          cyc++;
        end
        out_ready_d = 1'b0;
        repeat (3) begin
          @(negedge clk);
          n_cmp++;
          if ({obs_valid, obs_cout, obs_sum, obs_ovf} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL stall_hold: valid=%0d cout=%0d sum=%h ovf=%0d, required valid=1 cout=0 sum=0000 ovf=0",
                     obs_valid, obs_cout, obs_sum, obs_ovf);
          end
          @(posedge clk);
          #1;
        end
        out_ready_d = 1'b1;
      end
      begin
        repeat (30) begin
          @(negedge clk);
          if (!obs_ready) lowcnt++;
        end
      end
    join
    wait_idle("b2b");
    n_cmp++;
    if (lowcnt != 3) begin
      n_bad++;
      $display("FAIL stall_in_ready: in_ready low for %0d cycles, required 3", lowcnt);
    end
    n_cmp++;
    if (n_emit - emit0 != 8) begin
      n_bad++;
      $display("FAIL b2b_count: %0d results, required 8", n_emit - emit0);
    end
  endtask

  task automatic test_reset_midflight();
    int vcnt;
    int cyc;
    for (int i = 0; i < 3; i++) begin
      a_d = 32'h0100 + i; b_d = 32'h0010 * i; cin_d = 1'b0; sub_d = 1'b0;
      drive_beat();
    end
    in_valid_d = 1'b0;
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_cmp++;
    if ({obs_valid, obs_cout, obs_ovf, obs_sum} !== 35'd0) begin
      n_bad++;
      $display("FAIL midreset_outputs: valid=%0d cout=%0d ovf=%0d sum=%h, required all 0",
               obs_valid, obs_cout, obs_ovf, obs_sum);
    end
    n_cmp++;
    if (obs_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL midreset_in_ready: got %0d, required 1", obs_ready);
    end
    #1;
    rst_n = 1'b1;
    vcnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (obs_valid) vcnt++;
    end
    n_cmp++;
    if (vcnt != 0) begin
      n_bad++;
      $display("FAIL midreset_stale: out_valid high %0d cycles after release, required 0", vcnt);
    end
    @(posedge clk);
    #1;
    a_d = 32'h1234; b_d = 32'h4321; cin_d = 1'b1; sub_d = 1'b0;
    drive_beat();
    in_valid_d = 1'b0;
    wait_valid(cyc);
    n_cmp++;
    if ({obs_valid, obs_cout, obs_sum, obs_ovf} !== {1'b1, 1'b0, 32'h5556, 1'b0}) begin
      n_bad++;
      $display("FAIL midreset_new: valid=%0d cout=%0d sum=%h ovf=%0d, required valid=1 cout=0 sum=5556 ovf=0",
               obs_valid, obs_cout, obs_sum, obs_ovf);
    end
    wait_idle("midreset");
  endtask

  task automatic test_random(input int s, input int nbeats);
    int acc0;
    int cyc;
    sel  = s;
    acc0 = n_accept;
    cyc  = 0;
    while ((n_accept - acc0) < nbeats && cyc < nbeats * 10) begin
      a_d = $urandom;
      b_d = $urandom;
      if ($urandom_range(0, 7) == 0) a_d = 32'hFFFF_FFFF;
      if ($urandom_range(0, 7) == 0) b_d = 32'h8000_8000;
      cin_d       = 1'($urandom_range(0, 1));
      sub_d       = 1'($urandom_range(0, 1));
      in_valid_d  = ($urandom_range(0, 3) != 0);
      out_ready_d = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
      cyc++;
    end
    in_valid_d  = 1'b0;
    out_ready_d = 1'b1;
    n_cmp++;
    if ((n_accept - acc0) != nbeats) begin
      n_bad++;
      $display("FAIL random_accepts(cfg%0d): %0d beats accepted, required %0d", s, n_accept - acc0, nbeats);
    end
    wait_idle("random");
  endtask

  initial begin
    rst_n       = 1'b0;
    in_valid_d  = 1'b0;
    out_ready_d = 1'b1;
    a_d         = '0;
    b_d         = '0;
    cin_d       = 1'b0;
    sub_d       = 1'b0;
    sel         = 0;
    test_reset();
    test_carry_chain();
    test_overflow();
    test_borrow();
    test_back_to_back();
    test_reset_midflight();
    test_random(0, 10000);
    test_random(1, 3000);
    test_random(2, 3000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
